// File: rtl/conv1x1_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv1x1_loader_pkg
// Description : Shared widths, path bit positions and FSM encoding for the
//               conv1x1 weight loader.
// Revision    : 1.0 - initial release
// ============================================================================
package conv1x1_loader_pkg;

    localparam int WORD_W   = 16;
    localparam int IDX_W    = 16;
    localparam int RES_BIT  = 1;
    localparam int SKIP_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD_RES  = 2'd1,
        ST_LOAD_SKIP = 2'd2,
        ST_DONE      = 2'd3
    } loader_state_e;

endpackage
`default_nettype wire

// File: rtl/conv1x1_weight_loader_index_counter.sv
`default_nettype none
// ============================================================================
// Module      : conv1x1_index_counter
// Description : Nested 2-D counter (inner wraps into outer) with clear,
//               enable and a last-position flag.
// Revision    : 1.0 - initial release
// ============================================================================
module conv1x1_index_counter
    import conv1x1_loader_pkg::*;
#(
    parameter int INNER_COUNT = 512,
    parameter int OUTER_COUNT = 512
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [IDX_W-1:0] o_inner,
    output logic [IDX_W-1:0] o_outer,
    output logic             o_last
);

    localparam logic [IDX_W-1:0] c_INNER_LAST = IDX_W'(INNER_COUNT - 1);
    localparam logic [IDX_W-1:0] c_OUTER_LAST = IDX_W'(OUTER_COUNT - 1);

    logic [IDX_W-1:0] r_inner;
    logic [IDX_W-1:0] r_outer;
    logic             w_inner_last;
    logic             w_outer_last;

    assign w_inner_last = (r_inner == c_INNER_LAST);
    assign w_outer_last = (r_outer == c_OUTER_LAST);

    always_ff @(posedge clk) begin
        if (!reset || i_clear) begin
            r_inner <= '0;
            r_outer <= '0;
        end else if (i_enable) begin
            if (w_inner_last) begin
                r_inner <= '0;
                r_outer <= w_outer_last ? '0 : r_outer + 1'b1;
            end else begin
                r_inner <= r_inner + 1'b1;
            end
        end
    end

    assign o_inner = r_inner;
    assign o_outer = r_outer;
    assign o_last  = w_inner_last && w_outer_last;

endmodule
`default_nettype wire

// File: rtl/conv1x1_weight_loader.sv
`default_nettype none
// ============================================================================
// Module      : conv1x1_weight_loader
// Description : Streams conv1x1 weights into the residual and/or skip path
//               tables, emitting one registered write strobe per word.
// Revision    : 1.0 - initial release
// ============================================================================
module conv1x1_weight_loader
    import conv1x1_loader_pkg::*;
#(
    parameter int INPUT_CHANNELS  = 512,
    parameter int OUTPUT_CHANNELS = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        path_mask,
    input  logic              abort,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [WORD_W-1:0] w_data,
    output logic [1:0]        conv1x1_h_write,
    output logic [IDX_W-1:0]  conv1x1_h_index_in,
    output logic [IDX_W-1:0]  conv1x1_h_index_out,
    output logic [WORD_W-1:0] conv1x1_h_value,
    output logic              busy,
    output logic              done
);

    loader_state_e     r_state;
    loader_state_e     w_next_state;
    logic [1:0]        r_mask;
    logic [1:0]        r_h_write;
    logic [IDX_W-1:0]  r_index_in;
    logic [IDX_W-1:0]  r_index_out;
    logic [WORD_W-1:0] r_value;

    logic              w_busy;
    logic              w_start;
    logic              w_xfer;
    logic [1:0]        w_strobe;
    logic [IDX_W-1:0]  w_cnt_in;
    logic [IDX_W-1:0]  w_cnt_out;
    logic              w_cnt_last;

    assign w_busy  = (r_state == ST_LOAD_RES) || (r_state == ST_LOAD_SKIP);
    // abort blocks acceptance in its own cycle, so the word on the bus is dropped
    assign w_xfer  = w_busy && w_valid && !abort;
    assign w_start = (r_state == ST_IDLE) && start && !abort;

    conv1x1_index_counter #(
        .INNER_COUNT (INPUT_CHANNELS),
        .OUTER_COUNT (OUTPUT_CHANNELS)
    ) u_index_counter (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_start || abort),
        .i_enable (w_xfer),
        .o_inner  (w_cnt_in),
        .o_outer  (w_cnt_out),
        .o_last   (w_cnt_last)
    );

    always_comb begin
        w_next_state = r_state;
        w_strobe     = 2'b00;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (path_mask[RES_BIT])       w_next_state = ST_LOAD_RES;
                    else if (path_mask[SKIP_BIT]) w_next_state = ST_LOAD_SKIP;
                    else                          w_next_state = ST_DONE;
                end
            end
            ST_LOAD_RES: begin
                w_strobe[RES_BIT] = 1'b1;
                if (w_xfer && w_cnt_last)
                    w_next_state = r_mask[SKIP_BIT] ? ST_LOAD_SKIP : ST_DONE;
            end
            ST_LOAD_SKIP: begin
                w_strobe[SKIP_BIT] = 1'b1;
                if (w_xfer && w_cnt_last)
                    w_next_state = ST_DONE;
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
        if (abort)
            w_next_state = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_mask      <= 2'b00;
            r_h_write   <= 2'b00;
            r_index_in  <= '0;
            r_index_out <= '0;
            r_value     <= '0;
        end else begin
            r_state   <= w_next_state;
            r_h_write <= 2'b00;
            if (w_start)
                r_mask <= path_mask;
            if (abort || w_start) begin
                r_index_in  <= '0;
                r_index_out <= '0;
            end else if (w_xfer) begin
                r_h_write   <= w_strobe;
                r_index_in  <= w_cnt_in;
                r_index_out <= w_cnt_out;
                r_value     <= w_data;
            end
        end
    end

    assign w_ready             = w_busy && !abort;
    assign busy                = w_busy;
    assign done                = (r_state == ST_DONE);
    assign conv1x1_h_write     = r_h_write;
    assign conv1x1_h_index_in  = r_index_in;
    assign conv1x1_h_index_out = r_index_out;
    assign conv1x1_h_value     = r_value;

endmodule
`default_nettype wire

// File: tb/tb_conv1x1_weight_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv1x1_weight_loader
// Description : Drives a 2x3 and a 1x1 loader with shared stimulus and checks
//               both against a queue-based model of the expected write list.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv1x1_weight_loader;

    logic        clk = 1'b0;
    logic        reset, start, abort, w_valid;
    logic [1:0]  path_mask;
    logic [15:0] w_data;

    logic [1:0]  hw  [2];
    logic [15:0] ixi [2];
    logic [15:0] ixo [2];
    logic [15:0] val [2];
    logic        rdy [2];
    logic        bsy [2];
    logic        dn  [2];

    always #5 clk = ~clk;

    conv1x1_weight_loader #(.INPUT_CHANNELS(2), .OUTPUT_CHANNELS(3)) u_dut (
        .clk(clk), .reset(reset), .start(start), .path_mask(path_mask),
        .abort(abort), .w_valid(w_valid), .w_ready(rdy[0]), .w_data(w_data),
        .conv1x1_h_write(hw[0]), .conv1x1_h_index_in(ixi[0]),
        .conv1x1_h_index_out(ixo[0]), .conv1x1_h_value(val[0]),
        .busy(bsy[0]), .done(dn[0])
    );

    conv1x1_weight_loader #(.INPUT_CHANNELS(1), .OUTPUT_CHANNELS(1)) u_dut_1x1 (
        .clk(clk), .reset(reset), .start(start), .path_mask(path_mask),
        .abort(abort), .w_valid(w_valid), .w_ready(rdy[1]), .w_data(w_data),
        .conv1x1_h_write(hw[1]), .conv1x1_h_index_in(ixi[1]),
        .conv1x1_h_index_out(ixo[1]), .conv1x1_h_value(val[1]),
        .busy(bsy[1]), .done(dn[1])
    );

    typedef struct {
        bit res;
        int ii;
        int oo;
    } wr_t;

    // Model: the full list of pending writes is built when a load is accepted
    wr_t         mq [2][$];
    bit          m_load [2];
    bit          m_done [2];
    bit          m_live = 1'b0;
    logic [1:0]  m_hw   [2];
    int          m_in   [2];
    int          m_out  [2];
    logic [15:0] m_val  [2];

    int n_checks = 0;
    int n_errors = 0;
    int n_res  [2] = '{0, 0};
    int n_skip [2] = '{0, 0};
    int n_done [2] = '{0, 0};
    int b_res  [2];
    int b_skip [2];
    int b_done [2];

    function automatic int in_n(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic int out_n(input int i);
        return (i == 0) ? 3 : 1;
    endfunction

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int i);
        wr_t e;
        bit  done_prev;
        m_hw[i] = 2'b00;
        if (!reset) begin
            mq[i].delete();
            m_load[i] = 1'b0;
            m_done[i] = 1'b0;
            m_in[i]   = 0;
            m_out[i]  = 0;
            m_val[i]  = '0;
        end else begin
            done_prev = m_done[i];
            m_done[i] = 1'b0;
            if (abort) begin
                mq[i].delete();
                m_load[i] = 1'b0;
                m_in[i]   = 0;
                m_out[i]  = 0;
            end else if (m_load[i]) begin
                if (w_valid) begin
                    e = mq[i].pop_front();
                    m_hw[i]  = e.res ? 2'b10 : 2'b01;
                    m_in[i]  = e.ii;
                    m_out[i] = e.oo;
                    m_val[i] = w_data;
                    if (mq[i].size() == 0) begin
                        m_load[i] = 1'b0;
                        m_done[i] = 1'b1;
                    end
                end
            end else if (!done_prev && start) begin
                for (int p = 1; p >= 0; p--)
                    if (path_mask[p])
                        for (int o = 0; o < out_n(i); o++)
                            for (int n = 0; n < in_n(i); n++) begin
                                e.res = (p == 1);
                                e.ii  = n;
                                e.oo  = o;
                                mq[i].push_back(e);
                            end
                m_in[i]  = 0;
                m_out[i] = 0;
                if (mq[i].size() == 0) m_done[i] = 1'b1;
                else                   m_load[i] = 1'b1;
            end
        end
    endtask

    always @(posedge clk) begin
        if (!reset) m_live = 1'b1;
        for (int i = 0; i < 2; i++) model_step(i);
    end

    always @(negedge clk) begin
        if (m_live) begin
            for (int i = 0; i < 2; i++) begin
                check_value($sformatf("u%0d_h_write", i), 32'(hw[i]), 32'(m_hw[i]));
                check_value($sformatf("u%0d_index_in", i), 32'(ixi[i]), 32'(m_in[i]));
                check_value($sformatf("u%0d_index_out", i), 32'(ixo[i]), 32'(m_out[i]));
                check_value($sformatf("u%0d_value", i), 32'(val[i]), 32'(m_val[i]));
                check_value($sformatf("u%0d_w_ready", i), 32'(rdy[i]), 32'(m_load[i] && !abort));
                check_value($sformatf("u%0d_busy", i), 32'(bsy[i]), 32'(m_load[i]));
                check_value($sformatf("u%0d_done", i), 32'(dn[i]), 32'(m_done[i]));
                if (hw[i] == 2'b10) n_res[i]++;
                if (hw[i] == 2'b01) n_skip[i]++;
                if (dn[i])          n_done[i]++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        for (int i = 0; i < 2; i++) begin
            b_res[i]  = n_res[i];
            b_skip[i] = n_skip[i];
            b_done[i] = n_done[i];
        end
    endtask

    task automatic check_counts(input string tag, input int i, input int res, input int skip, input int dne);
        check_value({tag, "_res"},  32'(n_res[i]  - b_res[i]),  32'(res));
        check_value({tag, "_skip"}, 32'(n_skip[i] - b_skip[i]), 32'(skip));
        check_value({tag, "_done"}, 32'(n_done[i] - b_done[i]), 32'(dne));
    endtask

    task automatic start_load(input logic [1:0] m);
        start     = 1'b1;
        path_mask = m;
        tick();
        start     = 1'b0;
        path_mask = 2'($urandom);
    endtask

    task automatic idle_ticks(input int n);
        w_valid = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; path_mask = 2'b00;
        w_valid = 1'b0; w_data = '0;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // Both paths, back-to-back words 1..12
        snap();
        start_load(2'b11);
        for (int k = 1; k <= 12; k++) begin
            w_valid = 1'b1;
            w_data  = 16'(k);
            tick();
        end
        idle_ticks(3);
        check_counts("both_2x3", 0, 6, 6, 1);
        check_counts("both_1x1", 1, 1, 1, 1);

        // Skip path only, w_valid toggling
        snap();
        start_load(2'b01);
        for (int k = 0; k < 40 && (m_load[0] || m_load[1]); k++) begin
            w_valid = (k % 2 == 0);
            w_data  = 16'($urandom);
            tick();
        end
        idle_ticks(3);
        check_value("skip_timeout", 32'(m_load[0]), 32'd0);
        check_counts("skip_2x3", 0, 0, 6, 1);
        check_counts("skip_1x1", 1, 0, 1, 1);

        // Empty mask
        snap();
        start_load(2'b00);
        idle_ticks(3);
        check_counts("empty_2x3", 0, 0, 0, 1);
        check_counts("empty_1x1", 1, 0, 0, 1);

        // Abort after four residual words, word present in abort cycle
        snap();
        start_load(2'b11);
        for (int k = 0; k < 4; k++) begin
            w_valid = 1'b1;
            w_data  = 16'($urandom);
            tick();
        end
        abort   = 1'b1;
        w_valid = 1'b1;
        w_data  = 16'hDEAD;
        tick();
        abort = 1'b0;
        idle_ticks(3);
        check_counts("abort_2x3", 0, 4, 0, 0);

        // Restart after abort
        snap();
        start_load(2'b10);
        for (int k = 0; k < 6; k++) begin
            w_valid = 1'b1;
            w_data  = 16'($urandom);
            tick();
        end
        idle_ticks(3);
        check_counts("restart_2x3", 0, 6, 0, 1);
        check_counts("restart_1x1", 1, 1, 0, 1);

        // Reset mid skip path, start pulsed while busy
        snap();
        start_load(2'b11);
        for (int k = 0; k < 8; k++) begin
            w_valid   = 1'b1;
            w_data    = 16'($urandom);
            start     = (k == 3);
            path_mask = 2'($urandom);
            tick();
        end
        start   = 1'b0;
        reset   = 1'b0;
        w_valid = 1'b1;
        tick();
        reset = 1'b1;
        idle_ticks(3);
        check_counts("rst_2x3", 0, 6, 2, 0);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            reset     = ($urandom_range(0, 199) != 0);
            start     = ($urandom_range(0, 7) == 0);
            path_mask = 2'($urandom);
            abort     = ($urandom_range(0, 29) == 0);
            w_valid   = 1'($urandom_range(0, 1));
            w_data    = 16'($urandom);
            tick();
        end
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        for (int k = 0; k < 50 && (m_load[0] || m_load[1]); k++) begin
            w_valid = 1'b1;
            w_data  = 16'($urandom);
            tick();
        end
        idle_ticks(3);
        check_value("drain_timeout", 32'(m_load[0] || m_load[1]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
